// File: rtl/breath_led_array_if.sv
// Control and LED-drive bundle between the stopwatch controller and the breathing-LED driver.
// The controller side drives enable/hold/restart/mode; the driver returns the LED drive and ramp status.
interface breath_led_array_if #(
   parameter int CHANNELS = 4,
   parameter int PWM_BITS = 10
);
   logic                  enable;
   logic                  hold;
   logic                  restart;
   logic [2*CHANNELS-1:0] mode;
   logic [CHANNELS-1:0]   led;
   logic [PWM_BITS-1:0]   level;
   logic                  breath_done;

   modport master (
      output enable, hold, restart, mode,
      input  led, level, breath_done
   );

   modport slave (
      input  enable, hold, restart, mode,
      output led, level, breath_done
   );
endinterface

// File: rtl/breath_led_array.sv
// Multi-channel breathing-LED driver: a shared prescaler, PWM counter and triangle ramp feed
// per-channel off / on / breathe / antiphase-breathe outputs.
//
// dir | meaning
// UP  | level counting toward MAX on each step
// DN  | level counting toward 0 on each step
module breath_led_array #(
   parameter int CHANNELS     = 4,
   parameter int CLK_DIV      = 50,
   parameter int PWM_BITS     = 10,
   parameter int STEP_PERIODS = 1
) (
   input  logic             CLK_50MHz,
   input  logic             reset_n,
   breath_led_array_if.slave bus
);
   localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int STEP_W  = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
   localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(CLK_DIV - 1);
   localparam logic [STEP_W-1:0]   STEP_LAST  = STEP_W'(STEP_PERIODS - 1);
   localparam logic [PWM_BITS-1:0] MAX        = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] ONE        = PWM_BITS'(1);
   localparam logic [0:0]          DIR_UP     = 1'b0;
   localparam logic [0:0]          DIR_DN     = 1'b1;

   logic [PRESC_W-1:0]  r_presc;
   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic [STEP_W-1:0]   r_step_cnt;
   logic [PWM_BITS-1:0] r_level;
   logic [0:0]          r_dir;
   logic [CHANNELS-1:0] r_led;
   logic                r_breath_done;

   logic                w_tick;
   logic                w_pwm_wrap;
   logic                w_step_last;
   logic                w_step_evt;
   logic [CHANNELS-1:0] w_led_nxt;

   assign w_tick      = (r_presc == PRESC_LAST);
   assign w_pwm_wrap  = w_tick && (r_pwm_cnt == MAX);
   assign w_step_last = (r_step_cnt == STEP_LAST);
   assign w_step_evt  = w_pwm_wrap && w_step_last && !bus.hold;

   always_ff @(posedge CLK_50MHz) begin
      if (!reset_n || bus.restart) begin
         r_presc    <= '0;
         r_pwm_cnt  <= '0;
         r_step_cnt <= '0;
         r_level    <= '0;
         r_dir      <= DIR_UP;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         if (w_tick)
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
         // hold freezes the step counter too, so a pending step fires right after release
         if (w_pwm_wrap && !bus.hold)
            r_step_cnt <= w_step_last ? '0 : r_step_cnt + 1'b1;
         if (w_step_evt) begin
            case (r_dir)
               DIR_UP: begin
                  if (r_level == MAX) begin
                     r_dir   <= DIR_DN;
                     r_level <= MAX - ONE;
                  end else begin
                     r_level <= r_level + ONE;
                  end
               end
               default: begin
                  if (r_level == '0) begin
                     r_dir   <= DIR_UP;
                     r_level <= ONE;
                  end else begin
                     r_level <= r_level - ONE;
                  end
               end
            endcase
         end
      end
   end

   always_comb begin
      w_led_nxt = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         case (bus.mode[2*i +: 2])
            2'b01:   w_led_nxt[i] = 1'b1;
            2'b10:   w_led_nxt[i] = (r_pwm_cnt < r_level);
            2'b11:   w_led_nxt[i] = (r_pwm_cnt < (MAX - r_level));
            default: w_led_nxt[i] = 1'b0;
         endcase
      end
      if (!bus.enable)
         w_led_nxt = '0;
   end

   always_ff @(posedge CLK_50MHz) begin
      if (!reset_n) begin
         r_led         <= '0;
         r_breath_done <= 1'b0;
      end else begin
         r_led         <= w_led_nxt;
         r_breath_done <= w_step_evt && !bus.restart && (r_dir == DIR_DN) && (r_level == ONE);
      end
   end

   assign bus.led         = r_led;
   assign bus.level       = r_level;
   assign bus.breath_done = r_breath_done;
endmodule
